push_arbiter: RTL and testbench

Parametrised N-channel push-button front end for the game datapath: each synchronized push input is debounced, edge-detected in a selectable mode, and fed to a first-press arbiter that latches a single round winner. It sits between the input synchronizers and the game controller. Generalises the single-channel rising-edge round-win detector to N channels, configurable debounce depth, selectable edge polarity, and false-start flagging.

---
 rtl/push_arbiter_pkg.sv | 14 +
 rtl/push_arbiter_if.sv | 21 ++
 rtl/push_debounce.sv | 52 +++++
 rtl/push_arbiter.sv | 72 +++++++
 tb/tb_push_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/push_arbiter_pkg.sv
// Shared types and constants for the push-button arbiter front end.
package push_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/push_arbiter_if.sv
// Bundle of push inputs, round control and arbiter results.
interface push_arbiter_if #(parameter int NCH = 2);
    logic [NCH-1:0] sypush;
    logic           arm;
    logic           clear;
    logic [NCH-1:0] edge_o;
    logic [NCH-1:0] early;
    logic [NCH-1:0] winner;
    logic           win_valid;
    logic           armed;

    modport master (
        output sypush, arm, clear,
        input  edge_o, early, winner, win_valid, armed
    );

    modport slave (
        input  sypush, arm, clear,
        output edge_o, early, winner, win_valid, armed
    );
endinterface

// File: rtl/push_debounce.sv
// Single-channel debouncer: accepts a level change after DEBOUNCE
// consecutive differing samples and emits a registered, mode-qualified edge.
module push_debounce
    import push_arbiter_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int MODE     = EDGE_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic sypush,
    output logic edge_o
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          edge_q, edge_d;

    // Count differing samples; flip the stable level once the run is long enough.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        edge_d = 1'b0;
        if (sypush == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            lvl_d = sypush;
            cnt_d = '0;
            if (MODE == EDGE_RISE)      edge_d = sypush;
            else if (MODE == EDGE_FALL) edge_d = ~sypush;
            else                        edge_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Level resets high so a button held through reset must be released first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q  <= 1'b1;
            cnt_q  <= '0;
            edge_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;
endmodule

// File: rtl/push_arbiter.sv
// N-channel push front end: per-channel debounce plus first-press round arbiter.
module push_arbiter
    import push_arbiter_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int DEBOUNCE = 4,
    parameter int MODE     = EDGE_RISE
) (
    input  logic            clk,
    input  logic            rst,
    push_arbiter_if.slave   bus
);
    logic [NCH-1:0] edge_w;
    state_e         state_q, state_d;
    logic [NCH-1:0] winner_q, winner_d;
    logic [NCH-1:0] early_q, early_d;
    logic           armed_w, win_valid_w;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        push_debounce #(.DEBOUNCE(DEBOUNCE), .MODE(MODE)) u_db (
            .clk    (clk),
            .rst    (rst),
            .sypush (bus.sypush[g]),
            .edge_o (edge_w[g])
        );
    end

    // State, winner and false-start registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            early_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            early_q  <= early_d;
        end
    end

    // Next state: clear dominates; the lowest-index edge wins an armed round.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        early_d  = (state_q == ST_IDLE) ? edge_w : '0;
        if (bus.clear) begin
            state_d  = ST_IDLE;
            winner_d = '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.arm) state_d = ST_ARMED;
                ST_ARMED: if (|edge_w) begin
                    state_d  = ST_LOCKED;
                    winner_d = edge_w & (~edge_w + NCH'(1));
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        armed_w     = (state_q == ST_ARMED);
        win_valid_w = (state_q == ST_LOCKED);
    end

    assign bus.edge_o    = edge_w;
    assign bus.early     = early_q;
    assign bus.winner    = winner_q;
    assign bus.win_valid = win_valid_w;
    assign bus.armed     = armed_w;
endmodule

// File: tb/tb_push_arbiter.sv
// Bench for push_arbiter: two configurations (D=4 rising, D=1 both edges)
// driven with the same stimulus and compared against a behavioural model.
module tb_push_arbiter;
    import push_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sp = 2'b11;
    logic       arm_r = 1'b0;
    logic       clr_r = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    push_arbiter_if #(.NCH(2)) ifa ();
    push_arbiter_if #(.NCH(2)) ifb ();

    assign ifa.sypush = sp;
    assign ifa.arm    = arm_r;
    assign ifa.clear  = clr_r;
    assign ifb.sypush = sp;
    assign ifb.arm    = arm_r;
    assign ifb.clear  = clr_r;

    push_arbiter #(.NCH(2), .DEBOUNCE(4), .MODE(EDGE_RISE)) u_dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    push_arbiter #(.NCH(2), .DEBOUNCE(1), .MODE(EDGE_BOTH)) u_dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    // Reference model: config 0 = D4/rising, config 1 = D1/both.
    int         d_m    [2] = '{4, 1};
    int         mode_m [2] = '{0, 2};
    logic [1:0] hist   [2][4];
    logic [1:0] lvl_m  [2];
    logic [1:0] edge_m [2];
    logic [1:0] early_m[2];
    logic [1:0] win_m  [2];
    int         st_m   [2];   // 0 idle, 1 armed, 2 locked

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            lvl_m[k] = 2'b11; edge_m[k] = 0; early_m[k] = 0; win_m[k] = 0; st_m[k] = 0;
            for (int j = 0; j < 4; j++) hist[k][j] = 2'b11;
        end
    endtask

    // One clock of the model: round logic sees last cycle's edges; a level
    // flips when the last D samples all disagree with it.
    task automatic model_step();
        logic [1:0] en, w;
        bit all_diff, newv;
        for (int k = 0; k < 2; k++) begin
            early_m[k] = (st_m[k] == 0) ? edge_m[k] : 2'b00;
            if (clr_r) begin
                st_m[k] = 0; win_m[k] = 0;
            end else if (st_m[k] == 0 && arm_r) begin
                st_m[k] = 1;
            end else if (st_m[k] == 1 && edge_m[k] != 0) begin
                w = 0;
                for (int c = 0; c < 2; c++) if (edge_m[k][c] && w == 0) w[c] = 1'b1;
                st_m[k] = 2; win_m[k] = w;
            end
            for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = sp;
            en = 0;
            for (int c = 0; c < 2; c++) begin
                all_diff = 1;
                for (int j = 0; j < d_m[k]; j++) if (hist[k][j][c] == lvl_m[k][c]) all_diff = 0;
                if (all_diff) begin
                    newv = ~lvl_m[k][c];
                    lvl_m[k][c] = newv;
                    if (mode_m[k] == 2 || (mode_m[k] == 0 && newv) || (mode_m[k] == 1 && !newv))
                        en[c] = 1'b1;
                end
            end
            edge_m[k] = en;
        end
    endtask

    task automatic tick(input logic [1:0] p, input logic a, input logic c);
        sp = p; arm_r = a; clr_r = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) tick(p, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ifa.edge_o, ifa.early, ifa.winner, ifa.win_valid, ifa.armed} !== 8'h00) begin
            errors++;
            $display("FAIL reset_a: got %b want 0", {ifa.edge_o, ifa.early, ifa.winner, ifa.win_valid, ifa.armed});
        end
        checks++;
        if ({ifb.edge_o, ifb.early, ifb.winner, ifb.win_valid, ifb.armed} !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: got %b want 0", {ifb.edge_o, ifb.early, ifb.winner, ifb.win_valid, ifb.armed});
        end
        #19 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick(2'b11, 1'b0, 1'b0);
            checks++;
            if (ifa.edge_o !== 2'b00 || ifb.edge_o !== 2'b00) begin
                errors++;
                $display("FAIL held_through_reset: got a=%b b=%b want 00", ifa.edge_o, ifb.edge_o);
            end
        end
    endtask

    task automatic test_press_latency();
        logic [1:0] exp;
        settle(2'b00, 6);
        for (int n = 1; n <= 6; n++) begin
            tick(2'b01, 1'b0, 1'b0);
            exp = (n == 4) ? 2'b01 : 2'b00;
            checks++;
            if (ifa.edge_o !== exp) begin
                errors++;
                $display("FAIL press_latency n=%0d: got %b want %b", n, ifa.edge_o, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] exp;
        settle(2'b00, 6);
        for (int n = 0; n < 9; n++) begin
            tick((n < 3) ? 2'b10 : 2'b00, 1'b0, 1'b0);
            checks++;
            if (ifa.edge_o !== 2'b00) begin
                errors++;
                $display("FAIL glitch n=%0d: got %b want 00", n, ifa.edge_o);
            end
        end
        // A full press after the glitch still takes the whole debounce time.
        for (int n = 1; n <= 5; n++) begin
            tick(2'b10, 1'b0, 1'b0);
            exp = (n == 4) ? 2'b10 : 2'b00;
            checks++;
            if (ifa.edge_o !== exp) begin
                errors++;
                $display("FAIL post_glitch_press n=%0d: got %b want %b", n, ifa.edge_o, exp);
            end
        end
        settle(2'b00, 6);
    endtask

    task automatic test_winner();
        logic [1:0] early_acc = 0;
        tick(2'b00, 1'b0, 1'b1);
        tick(2'b00, 1'b1, 1'b0);
        checks++;
        if (ifa.armed !== 1'b1) begin
            errors++;
            $display("FAIL armed_rise: got %b want 1", ifa.armed);
        end
        for (int n = 0; n < 10; n++) begin
            tick((n < 2) ? 2'b10 : 2'b11, 1'b0, 1'b0);
            early_acc |= ifa.early;
        end
        checks++;
        if ({ifa.winner, ifa.win_valid, ifa.armed} !== 4'b1010) begin
            errors++;
            $display("FAIL first_press_winner: got w=%b v=%b a=%b want w=10 v=1 a=0",
                     ifa.winner, ifa.win_valid, ifa.armed);
        end
        checks++;
        if (early_acc !== 2'b00) begin
            errors++;
            $display("FAIL no_early_when_armed: got %b want 00", early_acc);
        end
        tick(2'b00, 1'b0, 1'b1);
        settle(2'b00, 6);
    endtask

    task automatic test_simultaneous();
        tick(2'b00, 1'b1, 1'b0);
        settle(2'b11, 6);
        checks++;
        if (ifa.winner !== 2'b01 || ifa.win_valid !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous: got w=%b v=%b want w=01 v=1", ifa.winner, ifa.win_valid);
        end
        tick(2'b00, 1'b0, 1'b1);
        checks++;
        if (ifa.winner !== 2'b00 || ifa.win_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_locked: got w=%b v=%b want 00/0", ifa.winner, ifa.win_valid);
        end
        settle(2'b00, 6);
    endtask

    task automatic test_early();
        for (int n = 1; n <= 6; n++) begin
            tick(2'b10, 1'b0, 1'b0);
            checks++;
            if (ifa.early !== ((n == 5) ? 2'b10 : 2'b00) || ifa.armed !== 1'b0 || ifa.win_valid !== 1'b0) begin
                errors++;
                $display("FAIL false_start n=%0d: got e=%b a=%b v=%b want e=%b a=0 v=0",
                         n, ifa.early, ifa.armed, ifa.win_valid, (n == 5) ? 2'b10 : 2'b00);
            end
        end
        tick(2'b10, 1'b1, 1'b1);
        tick(2'b10, 1'b0, 1'b0);
        checks++;
        if (ifa.armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_with_clear: got %b want 0", ifa.armed);
        end
    endtask

    task automatic test_mode_both();
        int pulses = 0;
        logic [1:0] seq [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        logic [1:0] exp [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        settle(2'b00, 3);
        for (int n = 0; n < 4; n++) begin
            tick(seq[n], 1'b0, 1'b0);
            if (ifb.edge_o != 0) pulses++;
            checks++;
            if (ifb.edge_o !== exp[n]) begin
                errors++;
                $display("FAIL both_edges n=%0d: got %b want %b", n, ifb.edge_o, exp[n]);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL both_edge_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_locked();
        tick(2'b00, 1'b0, 1'b1);
        tick(2'b00, 1'b1, 1'b0);
        tick(2'b10, 1'b0, 1'b0);
        tick(2'b10, 1'b0, 1'b0);
        checks++;
        if (ifb.winner !== 2'b10 || ifb.win_valid !== 1'b1) begin
            errors++;
            $display("FAIL locked_before_rst: got w=%b v=%b want 10/1", ifb.winner, ifb.win_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifb.winner, ifb.win_valid, ifb.armed, ifa.winner, ifa.win_valid, ifa.armed} !== 8'h00) begin
            errors++;
            $display("FAIL async_rst: got b=%b%b%b a=%b%b%b want 0",
                     ifb.winner, ifb.win_valid, ifb.armed, ifa.winner, ifa.win_valid, ifa.armed);
        end
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [1:0] p = 2'b11;
        logic [1:0] oe, oy, ow;
        logic       ov, oa;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 6) == 0) p[c] = ~p[c];
            tick(p, ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    oe = ifa.edge_o; oy = ifa.early; ow = ifa.winner; ov = ifa.win_valid; oa = ifa.armed;
                end else begin
                    oe = ifb.edge_o; oy = ifb.early; ow = ifb.winner; ov = ifb.win_valid; oa = ifb.armed;
                end
                checks++;
                if (oe !== edge_m[k]) begin
                    errors++; $display("FAIL rnd_edge cfg%0d n=%0d: got %b want %b", k, n, oe, edge_m[k]);
                end
                checks++;
                if (oy !== early_m[k]) begin
                    errors++; $display("FAIL rnd_early cfg%0d n=%0d: got %b want %b", k, n, oy, early_m[k]);
                end
                checks++;
                if (ow !== win_m[k]) begin
                    errors++; $display("FAIL rnd_winner cfg%0d n=%0d: got %b want %b", k, n, ow, win_m[k]);
                end
                checks++;
                if (ov !== (st_m[k] == 2) || oa !== (st_m[k] == 1)) begin
                    errors++;
                    $display("FAIL rnd_state cfg%0d n=%0d: got v=%b a=%b want v=%b a=%b",
                             k, n, ov, oa, st_m[k] == 2, st_m[k] == 1);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_latency();
        test_glitch();
        test_winner();
        test_simultaneous();
        test_early();
        test_mode_both();
        test_reset_locked();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
